mem_req_bridge: RTL and testbench
=================================

# mem_req_bridge

- Sits between the CPU core's MEMR/MEMW logic and `sdram_controller`.
- Accepts one read or write request at a time over a valid/ready port and drives the controller's separate read and write command ports.
- Waits for completion (`rd_ready` for reads, `busy` going low for writes) and returns exactly one response pulse per request.
- A timeout guarantees the CPU never hangs on a controller that does not answer.

## Interface
- `ADDR_W`, 25, width of request and controller addresses.
- `TIMEOUT_CYCLES`, 1023, cycles after acceptance before a request is forcibly completed with error; must be ≥ 4.
- `clk` in 1: clock for the whole block; CPU side and controller side are both synchronous to it.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, can accept.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address (CPU zero-extends its 16-bit address).
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle completion pulse; the consumer has no backpressure.
- `rsp_rdata` out 16: read data; valid only while `rsp_valid` is high.
- `rsp_err` out 1: high with `rsp_valid` when the request timed out.
- `timeout_err` out 1: sticky timeout flag, cleared only by `rst`.
- `ctl_wr_addr` out ADDR_W, `ctl_wr_data` out 16, `ctl_wr_enable` out 1: controller write command.
- `ctl_rd_addr` out ADDR_W, `ctl_rd_enable` out 1: controller read command.
- `ctl_rd_data` in 16, `ctl_rd_ready` in 1: controller read return.
- `ctl_busy` in 1: controller busy.

## Operation
- **States:** IDLE, ISSUE, GUARD, WAIT, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, register `req_we`, `req_addr` and `req_wdata`, clear the timeout counter, and go to ISSUE.
- **ISSUE:**
  - If `ctl_busy` = 0, drive the enable for this cycle only: `ctl_wr_enable` if the request is a write, otherwise `ctl_rd_enable`. Then go to GUARD.
  - If `ctl_busy` = 1, stay in ISSUE with both enables low.
- **GUARD:**
  - One cycle during which `ctl_busy` is ignored, because the controller raises busy one cycle after a command.
  - Read: if `ctl_rd_ready` = 1, capture `ctl_rd_data` and go to RESP; otherwise go to WAIT.
  - Write: always go to WAIT.
- **WAIT:**
  - Read: on `ctl_rd_ready`, capture `ctl_rd_data` and go to RESP.
  - Write: on `ctl_busy` = 0, go to RESP.
- **RESP:**
  - `rsp_valid` = 1 for one cycle, then go to IDLE.
- **Timeout:**
  - The counter increments every cycle in ISSUE, GUARD and WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 with no completion that cycle:
    - go to RESP;
    - `rsp_rdata` = 16'hDEAD;
    - `rsp_err` = 1;
    - set `timeout_err`.
  - Completion and expiry in the same cycle: completion wins, and `rsp_err` = 0.
- **Stray input:** `ctl_rd_ready` seen in IDLE, ISSUE or RESP, or during a write, is ignored and no data is captured.
- **Command outputs:**
  - `ctl_wr_addr`, `ctl_rd_addr` and `ctl_wr_data` are driven from the registered request throughout ISSUE through RESP.
  - They hold their last value in IDLE.
- `rsp_rdata` is 0 for write responses.
- **Reset:**
  - Reset at any point, including mid-operation, returns the block to IDLE, drops both enables, and discards any pending response; no `rsp_valid` is produced.
  - Reset values of all outputs are 0, including `req_ready` while `rst` is high. `req_ready` = 1 from the first cycle after reset is released.

## Timing
- Request accepted at cycle N (`req_valid` && `req_ready`); `req_ready` = 0 from N+1 until the block returns to IDLE.
- With `ctl_busy` = 0 at N+1, the enable pulses at N+1.
- Minimum read: `ctl_rd_ready` at N+2 gives `rsp_valid` at N+3.
- Minimum write: `ctl_busy` = 0 at N+3 gives `rsp_valid` at N+4.
- Back-to-back: the next request can be accepted the cycle after `rsp_valid`, giving at best one request per 4 cycles.
- Each cycle `ctl_busy` stays high in ISSUE delays the enable by one cycle.
- Timeout: `rsp_valid` with error at N + TIMEOUT_CYCLES + 1.
- Enables are never high for more than one consecutive cycle.
- Exactly one enable pulse and exactly one `rsp_valid` occur per accepted request.

## Structure
- Package `mem_bridge_pkg` holds:
  - the state enum (IDLE, ISSUE, GUARD, WAIT, RESP);
  - the constant `TIMEOUT_RDATA` = 16'hDEAD;
  - the typedef of the registered request record (`we`, `addr`, `wdata`).
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
- No sub-module: a single FSM plus counter in one file.

## Test plan
- **Read, minimal latency:** request (we=0, addr 0x00123) at N, `ctl_busy` = 0, `ctl_rd_ready` with data 0xBEEF at N+2 → `ctl_rd_enable` pulse at N+1 with `ctl_rd_addr` = 0x00123; `rsp_valid` at N+3 with `rsp_rdata` = 0xBEEF and `rsp_err` = 0.
- **Write with busy:** request (we=1, addr 0x00042, data 0x1234) at N; `ctl_busy` = 1 during N..N+2 → `ctl_wr_enable` at N+3 with data 0x1234; `ctl_busy` = 1 for 5 cycles then 0 → one `rsp_valid` in the cycle after busy first falls.
- **Timeout:** TIMEOUT_CYCLES = 8, read with `ctl_rd_ready` never asserted → `rsp_valid` at N+9 with `rsp_rdata` = 0xDEAD and `rsp_err` = 1; `timeout_err` stays 1 until `rst`.
- **Back-to-back:** write then read issued with `req_valid` held → second acceptance the cycle after the first `rsp_valid`; exactly 2 enables and 2 responses.
- **Reset mid-operation:** `rst` in WAIT of a read, then `ctl_rd_ready` pulses → no `rsp_valid`, all outputs 0 during reset, `req_ready` = 1 on the first cycle after reset.
- **Stray input:** `ctl_rd_ready` pulse while IDLE or during a write → ignored, with no `rsp_valid` and no data capture.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for mem_req_bridge.
//   state_e       : bridge FSM states
//   req_t         : registered copy of an accepted CPU request
//   TIMEOUT_RDATA : read data returned with a timed-out response
//   MAX_ADDR_W    : address field width of req_t; bridge ADDR_W must not exceed it
package mem_bridge_pkg;

  localparam int unsigned MAX_ADDR_W = 25;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [15:0]           wdata;
  } req_t;

endpackage

// File: rtl/mem_req_bridge_if.sv
// Bundle of the CPU request/response port and the sdram_controller command port.
//   slave  : view taken by mem_req_bridge (accepts requests, drives controller commands)
//   master : view taken by the environment (CPU issuing requests, controller answering)
// Request side : req_valid/req_ready/req_we/req_addr/req_wdata
// Response side: rsp_valid/rsp_rdata/rsp_err, sticky timeout_err
// Controller   : ctl_wr_*/ctl_rd_* commands, ctl_rd_data/ctl_rd_ready return, ctl_busy
interface mem_req_bridge_if #(
  parameter int unsigned ADDR_W = 25
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;

  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;
  logic              timeout_err;

  logic [ADDR_W-1:0] ctl_wr_addr;
  logic [15:0]       ctl_wr_data;
  logic              ctl_wr_enable;
  logic [ADDR_W-1:0] ctl_rd_addr;
  logic              ctl_rd_enable;
  logic [15:0]       ctl_rd_data;
  logic              ctl_rd_ready;
  logic              ctl_busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ctl_rd_data, ctl_rd_ready, ctl_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, timeout_err,
    output ctl_wr_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_addr, ctl_rd_enable
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output ctl_rd_data, ctl_rd_ready, ctl_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, timeout_err,
    input  ctl_wr_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_addr, ctl_rd_enable
  );

endinterface

// File: rtl/mem_req_bridge.sv
// Bridge between the CPU MEMR/MEMW request port and sdram_controller.
// Takes one request at a time, issues a single read or write command, waits for
// rd_ready (reads) or busy falling (writes) and returns exactly one rsp_valid pulse.
// A timeout counter forces an error response so the CPU never hangs.
// Ports:
//   clk : clock for both the CPU and controller sides
//   rst : synchronous active-high reset; all outputs read 0 while it is high
//   bus : mem_req_bridge_if.slave (request, response and controller command signals)
// Parameters:
//   ADDR_W         : request/controller address width (<= MAX_ADDR_W)
//   TIMEOUT_CYCLES : cycles after acceptance before forced error completion (>= 4)
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic             clk,
  input logic             rst,
  mem_req_bridge_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             timeout_err_q, timeout_err_d;

  logic active;
  logic done;
  logic timeout_hit;
  logic issue_now;

  // Completion and expiry are decided here so that completion can take priority.
  always_comb begin
    active = (state_q == StIssue) || (state_q == StGuard) || (state_q == StWait);
    done   = 1'b0;
    if (state_q == StGuard) begin
      // busy is not trusted in GUARD: the controller raises it a cycle late.
      done = !req_q.we && bus.ctl_rd_ready;
    end else if (state_q == StWait) begin
      done = req_q.we ? !bus.ctl_busy : bus.ctl_rd_ready;
    end
    timeout_hit = active && (cnt_q == CNT_LAST) && !done;
    // A command is not launched in the cycle the request is abandoned.
    issue_now   = (state_q == StIssue) && !bus.ctl_busy && !timeout_hit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    timeout_err_d = timeout_err_q;

    if (active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d     = StIssue;
          req_d.we    = bus.req_we;
          req_d.addr  = MAX_ADDR_W'(bus.req_addr);
          req_d.wdata = bus.req_wdata;
          cnt_d       = '0;
          rdata_d     = '0;
          err_d       = 1'b0;
        end
      end
      StIssue: begin
        if (issue_now) begin
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (!done && !timeout_hit) begin
          state_d = StWait;
        end
      end
      StWait: begin
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (done) begin
      state_d = StResp;
      if (!req_q.we) begin
        rdata_d = bus.ctl_rd_data;
      end
    end else if (timeout_hit) begin
      state_d       = StResp;
      rdata_d       = TIMEOUT_RDATA;
      err_d         = 1'b1;
      timeout_err_d = 1'b1;
    end
  end

  // Outputs; everything is forced low while reset is asserted.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_rdata     = '0;
    bus.rsp_err       = 1'b0;
    bus.timeout_err   = 1'b0;
    bus.ctl_wr_addr   = '0;
    bus.ctl_wr_data   = '0;
    bus.ctl_wr_enable = 1'b0;
    bus.ctl_rd_addr   = '0;
    bus.ctl_rd_enable = 1'b0;
    if (!rst) begin
      bus.req_ready     = (state_q == StIdle);
      bus.rsp_valid     = (state_q == StResp);
      bus.rsp_rdata     = (state_q == StResp) ? rdata_q : '0;
      bus.rsp_err       = (state_q == StResp) && err_q;
      bus.timeout_err   = timeout_err_q;
      // Command fields only change on acceptance, so they hold in IDLE.
      bus.ctl_wr_addr   = req_q.addr[ADDR_W-1:0];
      bus.ctl_rd_addr   = req_q.addr[ADDR_W-1:0];
      bus.ctl_wr_data   = req_q.wdata;
      bus.ctl_wr_enable = issue_now && req_q.we;
      bus.ctl_rd_enable = issue_now && !req_q.we;
    end
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Self-checking bench for mem_req_bridge.
// Main instance (TIMEOUT_CYCLES=16) is checked by a scoreboard monitor for responses and
// command pulses; a second instance (TIMEOUT_CYCLES=8) covers timeout behaviour.
module tb_mem_req_bridge;

  localparam int unsigned ADDR_W = 25;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_req_bridge_if #(.ADDR_W(ADDR_W)) bus ();
  mem_req_bridge_if #(.ADDR_W(ADDR_W)) bus8 ();

  mem_req_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_req_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  rsp_t exp_rsp[$];
  cmd_t exp_cmd[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;
  int   n_en     = 0;
  logic prev_en  = 1'b0;
  logic cur_en;
  rsp_t mon_rsp;
  cmd_t mon_cmd;
  int   en0, rs0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      n_rsp++;
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", 32'(exp_rsp.size()), 1);
      end else begin
        mon_rsp = exp_rsp.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_rsp.rdata));
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_rsp.err));
      end
    end
    cur_en = bus.ctl_wr_enable | bus.ctl_rd_enable;
    if (cur_en) begin
      n_en++;
      check("enable_exclusive", 32'(bus.ctl_wr_enable & bus.ctl_rd_enable), 0);
      check("enable_consecutive", 32'(prev_en), 0);
      if (exp_cmd.size() == 0) begin
        check("cmd_unexpected", 32'(exp_cmd.size()), 1);
      end else begin
        mon_cmd = exp_cmd.pop_front();
        check("cmd_is_write", 32'(bus.ctl_wr_enable), 32'(mon_cmd.we));
        if (mon_cmd.we) begin
          check("cmd_wr_addr", 32'(bus.ctl_wr_addr), 32'(mon_cmd.addr));
          check("cmd_wr_data", 32'(bus.ctl_wr_data), 32'(mon_cmd.wdata));
        end else begin
          check("cmd_rd_addr", 32'(bus.ctl_rd_addr), 32'(mon_cmd.addr));
        end
      end
    end
    prev_en = cur_en;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.timeout_err,
                               bus.ctl_wr_enable, bus.ctl_rd_enable}), 0);
    check({tag, "_addr"}, 32'(bus.ctl_rd_addr | bus.ctl_wr_addr), 0);
    check({tag, "_data"}, 32'(bus.ctl_wr_data | bus.rsp_rdata), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ctl_rd_data = '0; bus.ctl_rd_ready = 0; bus.ctl_busy = 0;
    bus8.req_valid = 0; bus8.req_we = 0; bus8.req_addr = '0; bus8.req_wdata = '0;
    bus8.ctl_rd_data = '0; bus8.ctl_rd_ready = 0; bus8.ctl_busy = 0;
    rst = 1'b1;

    // Reset state.
    repeat (3) begin
      step();
      sample();
    end
    check_reset_outputs("rst_init");
    step();
    rst = 1'b0;
    sample();
    check("rel_req_ready", 32'(bus.req_ready), 1);

    // Read, minimal latency.
    step();
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 25'h00123; bus.ctl_busy = 0;
    exp_cmd.push_back('{we: 1'b0, addr: 25'h00123, wdata: 16'h0});
    exp_rsp.push_back('{rdata: 16'hBEEF, err: 1'b0});
    sample();
    check("rd_accept_ready", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 0;
    sample();
    check("rd_en_n1", 32'(bus.ctl_rd_enable), 1);
    check("rd_ready_low_n1", 32'(bus.req_ready), 0);
    step();
    bus.ctl_rd_ready = 1; bus.ctl_rd_data = 16'hBEEF;
    sample();
    check("rd_no_rsp_n2", 32'(bus.rsp_valid), 0);
    step();
    bus.ctl_rd_ready = 0; bus.ctl_rd_data = 16'h0;
    sample();
    check("rd_rsp_n3", 32'(bus.rsp_valid), 1);
    step();
    sample();
    check("rd_ready_back", 32'(bus.req_ready), 1);

    // Stray rd_ready while idle.
    step();
    bus.ctl_rd_ready = 1; bus.ctl_rd_data = 16'h7777;
    sample();
    check("stray_idle_rsp", 32'(bus.rsp_valid), 0);
    step();
    bus.ctl_rd_ready = 0; bus.ctl_rd_data = 16'h0;
    sample();
    check("stray_idle_rsp_next", 32'(bus.rsp_valid), 0);

    // Write held off by busy, then long busy; stray rd_ready in the middle.
    step();
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 25'h00042; bus.req_wdata = 16'h1234;
    bus.ctl_busy = 1;
    exp_cmd.push_back('{we: 1'b1, addr: 25'h00042, wdata: 16'h1234});
    exp_rsp.push_back('{rdata: 16'h0, err: 1'b0});
    sample();
    check("wr_accept_ready", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 0;
    sample();
    check("wr_en_n1", 32'(bus.ctl_wr_enable), 0);
    step();
    sample();
    check("wr_en_n2", 32'(bus.ctl_wr_enable), 0);
    step();
    bus.ctl_busy = 0;
    sample();
    check("wr_en_n3", 32'(bus.ctl_wr_enable), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      bus.ctl_busy = 1;
      bus.ctl_rd_ready = (i == 1);
      bus.ctl_rd_data = (i == 1) ? 16'h5555 : 16'h0;
      sample();
      check("wr_busy_no_rsp", 32'(bus.rsp_valid), 0);
    end
    step();
    bus.ctl_busy = 0; bus.ctl_rd_ready = 0; bus.ctl_rd_data = 16'h0;
    sample();
    check("wr_no_rsp_n9", 32'(bus.rsp_valid), 0);
    step();
    sample();
    check("wr_rsp_n10", 32'(bus.rsp_valid), 1);
    step();
    sample();
    check("wr_ready_back", 32'(bus.req_ready), 1);

    // Back-to-back write then read with req_valid held.
    step();
    en0 = n_en;
    rs0 = n_rsp;
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 25'h00010; bus.req_wdata = 16'hAAAA;
    bus.ctl_busy = 0;
    exp_cmd.push_back('{we: 1'b1, addr: 25'h00010, wdata: 16'hAAAA});
    exp_rsp.push_back('{rdata: 16'h0, err: 1'b0});
    exp_cmd.push_back('{we: 1'b0, addr: 25'h00011, wdata: 16'h0});
    exp_rsp.push_back('{rdata: 16'hC0DE, err: 1'b0});
    sample();
    check("b2b_first_accept", 32'(bus.req_ready), 1);
    step();
    bus.req_we = 0; bus.req_addr = 25'h00011; bus.req_wdata = 16'h0;
    sample();
    check("b2b_busy_n1", 32'(bus.req_ready), 0);
    for (int i = 2; i <= 3; i++) begin
      step();
      sample();
      check("b2b_busy", 32'(bus.req_ready), 0);
    end
    step();
    sample();
    check("b2b_wr_rsp_n4", 32'(bus.rsp_valid), 1);
    check("b2b_ready_n4", 32'(bus.req_ready), 0);
    step();
    sample();
    check("b2b_second_accept", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 0;
    sample();
    check("b2b_rd_en_n6", 32'(bus.ctl_rd_enable), 1);
    step();
    bus.ctl_rd_ready = 1; bus.ctl_rd_data = 16'hC0DE;
    sample();
    step();
    bus.ctl_rd_ready = 0; bus.ctl_rd_data = 16'h0;
    sample();
    check("b2b_rd_rsp_n8", 32'(bus.rsp_valid), 1);
    step();
    check("b2b_enable_count", 32'(n_en - en0), 2);
    check("b2b_rsp_count", 32'(n_rsp - rs0), 2);

    // Reset while a read waits; the late rd_ready must not produce a response.
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 25'h00077;
    exp_cmd.push_back('{we: 1'b0, addr: 25'h00077, wdata: 16'h0});
    sample();
    step();
    bus.req_valid = 0;
    sample();
    check("mid_rst_rd_en", 32'(bus.ctl_rd_enable), 1);
    step();
    sample();
    step();
    sample();
    step();
    rst = 1'b1;
    sample();
    check_reset_outputs("mid_rst_a");
    step();
    sample();
    check_reset_outputs("mid_rst_b");
    step();
    rst = 1'b0; bus.ctl_rd_ready = 1; bus.ctl_rd_data = 16'h9999;
    sample();
    check("mid_rst_ready", 32'(bus.req_ready), 1);
    check("mid_rst_no_rsp", 32'(bus.rsp_valid), 0);
    step();
    bus.ctl_rd_ready = 0; bus.ctl_rd_data = 16'h0;
    sample();
    check("mid_rst_no_rsp_next", 32'(bus.rsp_valid), 0);

    // Timeout on the TIMEOUT_CYCLES=8 instance: read never answered.
    step();
    bus8.req_valid = 1; bus8.req_we = 0; bus8.req_addr = 25'h00055; bus8.ctl_busy = 0;
    sample();
    check("to_accept", 32'(bus8.req_ready), 1);
    step();
    bus8.req_valid = 0;
    sample();
    check("to_rd_en", 32'(bus8.ctl_rd_enable), 1);
    for (int k = 2; k <= 8; k++) begin
      step();
      sample();
      check("to_no_rsp_early", 32'(bus8.rsp_valid), 0);
    end
    step();
    sample();
    check("to_rsp_n9", 32'(bus8.rsp_valid), 1);
    check("to_rdata", 32'(bus8.rsp_rdata), 32'h0000DEAD);
    check("to_err", 32'(bus8.rsp_err), 1);
    check("to_sticky_n9", 32'(bus8.timeout_err), 1);
    step();
    sample();
    check("to_rsp_single", 32'(bus8.rsp_valid), 0);
    check("to_sticky_n10", 32'(bus8.timeout_err), 1);

    // Completion in the same cycle as expiry: completion wins.
    step();
    bus8.req_valid = 1; bus8.req_we = 0; bus8.req_addr = 25'h00066;
    sample();
    step();
    bus8.req_valid = 0;
    sample();
    for (int k = 2; k <= 7; k++) begin
      step();
      sample();
      check("race_no_rsp_early", 32'(bus8.rsp_valid), 0);
    end
    step();
    bus8.ctl_rd_ready = 1; bus8.ctl_rd_data = 16'h4321;
    sample();
    check("race_no_rsp_m8", 32'(bus8.rsp_valid), 0);
    step();
    bus8.ctl_rd_ready = 0; bus8.ctl_rd_data = 16'h0;
    sample();
    check("race_rsp_m9", 32'(bus8.rsp_valid), 1);
    check("race_rdata", 32'(bus8.rsp_rdata), 32'h00004321);
    check("race_err", 32'(bus8.rsp_err), 0);
    check("race_sticky", 32'(bus8.timeout_err), 1);

    // Sticky flag cleared only by reset.
    step();
    rst = 1'b1;
    sample();
    check("sticky_in_rst", 32'(bus8.timeout_err), 0);
    step();
    rst = 1'b0;
    sample();
    check("sticky_cleared", 32'(bus8.timeout_err), 0);
    check("post_rst_ready8", 32'(bus8.req_ready), 1);

    step();
    check("rsp_queue_drained", 32'(exp_rsp.size()), 0);
    check("cmd_queue_drained", 32'(exp_cmd.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
